// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared widths, the MEM-stage handshake state encoding and a helper that sizes
// the wait counter of the data-memory handshake.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int DATA_W = 24;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Width that holds 0..max_wait without wrapping.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// -----------------------------------------------------------------------------
// mem_handshake_fsm
// Data-memory req/ack sequencer for the MEM stage. Owns the IDLE/REQ/RESP state,
// the wait counter that bounds a request, the abort (err) flag and the captured
// read data that is handed to the MEM/WB register in RESP.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   access     in   current M instruction is a load or store
//   req_we     in   latched write flag of the outstanding request
//   mem_ack    in   one-cycle completion pulse from data memory
//   mem_rdata  in   read data, valid with mem_ack
//   state      out  current handshake state
//   stall      out  hold EX/MEM and earlier stages this cycle
//   mem_req    out  data-memory request
//   err        out  outstanding access was aborted (valid in RESP)
//   rdata      out  captured read data (valid in RESP)
// -----------------------------------------------------------------------------
module mem_handshake_fsm
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              access,
  input  logic              req_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output mem_state_t        state,
  output logic              stall,
  output logic              mem_req,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = wait_cnt_w(MAX_WAIT);
  // Counter value seen on the last REQ cycle before an abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              timeout;

  assign timeout = (cnt_reg == CNT_LAST);

  // State register (plus counter / err / data capture).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (access) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // Ack is checked first so an ack on the timeout edge still completes.
        if (mem_ack) begin
          state_next = RESP;
          rdata_next = req_we ? '0 : mem_rdata;
        end else if (timeout) begin
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = '0;
        err_next   = 1'b0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        err_next   = 1'b0;
        rdata_next = '0;
      end
    endcase
  end

  // Output decode: stall depends on state and access only, never on mem_ack,
  // so the upstream hold signal has no path from the memory response.
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    case (state_reg)
      IDLE: stall = access;
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
      end
      default: begin
        stall   = 1'b0;
        mem_req = 1'b0;
      end
    endcase
  end

  assign state = state_reg;
  assign err   = err_reg;
  assign rdata = rdata_reg;

endmodule

// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
// MEM stage of the 24-bit pipeline. Latches load/store requests, runs them
// through mem_handshake_fsm, stalls upstream while an access is in flight and
// registers the MEM/WB outputs. ResultW is the combinational writeback value
// that also feeds execute-stage forwarding.
// Ports:
//   clk, rst                      clock / asynchronous active-low reset
//   RegWriteM, MemWriteM,
//   ResultSrcM, RD_M, PCPlus4M,
//   ALU_ResultM, WriteDataM       EX/MEM register outputs
//   StallM                        hold EX/MEM and earlier stages
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata data-memory req/ack interface
//   RegWriteW, ResultSrcW, RD_W,
//   PCPlus4W, ALU_ResultW,
//   ReadDataW, MemErrW            MEM/WB register outputs
//   ResultW                       ResultSrcW ? ReadDataW : ALU_ResultW
// -----------------------------------------------------------------------------
module memory_cycle
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int REG_W    = pipeline_pkg::REG_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [REG_W-1:0]  RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [REG_W-1:0]  RD_W,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ResultW,
  output logic              MemErrW
);

  logic              access;
  mem_state_t        state;
  logic              hs_err;
  logic [DATA_W-1:0] hs_rdata;
  logic              resp;
  logic              commit_err;
  logic              latch_req;

  logic              mem_we_reg;
  logic [DATA_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic              reg_write_w_reg;
  logic              result_src_w_reg;
  logic [REG_W-1:0]  rd_w_reg;
  logic [DATA_W-1:0] pc_plus4_w_reg;
  logic [DATA_W-1:0] alu_result_w_reg;
  logic [DATA_W-1:0] read_data_w_reg;
  logic              mem_err_w_reg;

  // A store wins when both flags are set: mem_we simply follows MemWriteM.
  assign access     = MemWriteM | ResultSrcM;
  assign resp       = (state == RESP);
  assign commit_err = resp & hs_err;
  assign latch_req  = (state == IDLE) & access;

  mem_handshake_fsm #(
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_handshake (
    .clk       (clk),
    .rst       (rst),
    .access    (access),
    .req_we    (mem_we_reg),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .state     (state),
    .stall     (StallM),
    .mem_req   (mem_req),
    .err       (hs_err),
    .rdata     (hs_rdata)
  );

  // Request fields are captured once on entry to REQ and stay stable for the
  // whole handshake, independent of what upstream does with the M inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (latch_req) begin
      mem_we_reg    <= MemWriteM;
      mem_addr_reg  <= ALU_ResultM;
      mem_wdata_reg <= WriteDataM;
    end
  end

  // MEM/WB register. A stall cycle inserts a bubble (no write, no error) and
  // leaves the data fields as they were.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_w_reg  <= 1'b0;
      result_src_w_reg <= 1'b0;
      rd_w_reg         <= '0;
      pc_plus4_w_reg   <= '0;
      alu_result_w_reg <= '0;
      read_data_w_reg  <= '0;
      mem_err_w_reg    <= 1'b0;
    end else if (StallM) begin
      reg_write_w_reg  <= 1'b0;
      mem_err_w_reg    <= 1'b0;
    end else begin
      // An aborted load must not write the register file.
      reg_write_w_reg  <= RegWriteM & ~commit_err;
      result_src_w_reg <= ResultSrcM;
      rd_w_reg         <= RD_M;
      pc_plus4_w_reg   <= PCPlus4M;
      alu_result_w_reg <= ALU_ResultM;
      read_data_w_reg  <= resp ? hs_rdata : '0;
      mem_err_w_reg    <= commit_err;
    end
  end

  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

  assign RegWriteW   = reg_write_w_reg;
  assign ResultSrcW  = result_src_w_reg;
  assign RD_W        = rd_w_reg;
  assign PCPlus4W    = pc_plus4_w_reg;
  assign ALU_ResultW = alu_result_w_reg;
  assign ReadDataW   = read_data_w_reg;
  assign MemErrW     = mem_err_w_reg;

  assign ResultW     = result_src_w_reg ? read_data_w_reg : alu_result_w_reg;

endmodule

// File: tb/tb_memory_cycle.sv
// -----------------------------------------------------------------------------
// tb_memory_cycle
// Directed bench for memory_cycle: ALU pass-through, store and load handshakes,
// abort on timeout, asynchronous reset mid-request, stray ack and ack on the
// timeout edge.
// -----------------------------------------------------------------------------
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [23:0] PCPlus4M;
  logic [23:0] ALU_ResultM;
  logic [23:0] WriteDataM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ack;
  logic [23:0] mem_rdata;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [23:0] PCPlus4W;
  logic [23:0] ALU_ResultW;
  logic [23:0] ReadDataW;
  logic [23:0] ResultW;
  logic        MemErrW;

  int checks = 0;
  int fails  = 0;

  memory_cycle #(
    .DATA_W   (24),
    .REG_W    (5),
    .MAX_WAIT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .StallM      (StallM),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .ResultW     (ResultW),
    .MemErrW     (MemErrW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [23:0] pc, input logic [23:0] alu, input logic [23:0] wd);
    RegWriteM   = rw;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    RD_M        = rd;
    PCPlus4M    = pc;
    ALU_ResultM = alu;
    WriteDataM  = wd;
  endtask

  // Plays the data memory for one access already presented on the M inputs.
  // ack_on = n acks on the n-th REQ cycle (0 = never). Returns when StallM
  // drops (RESP cycle), with counts and request-field/bubble violation tallies.
  task automatic drive_access(input int ack_on, input logic [23:0] rd_val,
                              input logic exp_we, input logic [23:0] exp_addr,
                              input logic [23:0] exp_wdata,
                              output int stall_cyc, output int req_cyc,
                              output int fields_bad, output int bubble_bad,
                              output int timed_out);
    stall_cyc  = 0;
    req_cyc    = 0;
    fields_bad = 0;
    bubble_bad = 0;
    timed_out  = 1;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!StallM) begin
        timed_out = 0;
        break;
      end
      stall_cyc++;
      if (c > 0 && RegWriteW !== 1'b0) bubble_bad++;
      if (mem_req === 1'b1) begin
        req_cyc++;
        if (mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wdata) fields_bad++;
        if (req_cyc == ack_on) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val;
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({StallM, mem_req, mem_we} !== 3'b000) begin
      fails++;
      $display("FAIL test_reset ctrl: got StallM/req/we=%b required 000", {StallM, mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 48'h0) begin
      fails++;
      $display("FAIL test_reset req_fields: got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({RegWriteW, ResultSrcW, RD_W, MemErrW} !== 8'h00) begin
      fails++;
      $display("FAIL test_reset w_ctrl: got %b required 0", {RegWriteW, ResultSrcW, RD_W, MemErrW});
    end
    checks++;
    if ({PCPlus4W, ALU_ResultW, ReadDataW, ResultW} !== 96'h0) begin
      fails++;
      $display("FAIL test_reset w_data: got pc=%h alu=%h rd=%h res=%h required 0",
               PCPlus4W, ALU_ResultW, ReadDataW, ResultW);
    end
    #2 rst = 1'b1;
    tick();
    $display("[%0t] test_reset: released, StallM=%b mem_req=%b", $time, StallM, mem_req);
  endtask

  task automatic test_alu();
    set_m(1'b1, 1'b0, 1'b0, 5'd3, 24'h000100, 24'd42, 24'h0);
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      fails++;
      $display("FAIL test_alu stall: got %b required 0", StallM);
    end
    tick();
    checks++;
    if (RegWriteW !== 1'b1 || RD_W !== 5'd3) begin
      fails++;
      $display("FAIL test_alu wb_ctrl: got RegWriteW=%b RD_W=%0d required 1/3", RegWriteW, RD_W);
    end
    checks++;
    if (ResultW !== 24'd42 || PCPlus4W !== 24'h000100 || ReadDataW !== 24'h0) begin
      fails++;
      $display("FAIL test_alu wb_data: got ResultW=%h PCPlus4W=%h ReadDataW=%h required 00002a/000100/0",
               ResultW, PCPlus4W, ReadDataW);
    end
    $display("[%0t] test_alu: RD_W=%0d ResultW=%0d", $time, RD_W, ResultW);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic test_store();
    int sc, rc, fb, bb, to;
    set_m(1'b0, 1'b1, 1'b0, 5'd0, 24'h000104, 24'h000010, 24'h000007);
    drive_access(3, 24'h123456, 1'b1, 24'h000010, 24'h000007, sc, rc, fb, bb, to);
    checks++;
    if (to != 0 || sc != 4 || rc != 3) begin
      fails++;
      $display("FAIL test_store timing: got timeout=%0d stall=%0d req=%0d required 0/4/3", to, sc, rc);
    end
    checks++;
    if (fb != 0 || bb != 0) begin
      fails++;
      $display("FAIL test_store fields: got field_err=%0d bubble_err=%0d required 0/0", fb, bb);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL test_store resp_req: got mem_req=%b required 0", mem_req);
    end
    tick();
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
    #1;
    checks++;
    if (ReadDataW !== 24'h0 || ALU_ResultW !== 24'h000010 || RegWriteW !== 1'b0 || MemErrW !== 1'b0) begin
      fails++;
      $display("FAIL test_store commit: got rd=%h alu=%h rw=%b err=%b required 0/10/0/0",
               ReadDataW, ALU_ResultW, RegWriteW, MemErrW);
    end
    checks++;
    if (StallM !== 1'b0) begin
      fails++;
      $display("FAIL test_store post_stall: got %b required 0", StallM);
    end
    $display("[%0t] test_store: stall=%0d req=%0d", $time, sc, rc);
  endtask

  task automatic test_load();
    int sc, rc, fb, bb, to;
    set_m(1'b1, 1'b0, 1'b1, 5'd5, 24'h000204, 24'h000020, 24'h000555);
    drive_access(1, 24'hABCDEF, 1'b0, 24'h000020, 24'h000555, sc, rc, fb, bb, to);
    checks++;
    if (to != 0 || sc != 2 || rc != 1 || fb != 0 || bb != 0) begin
      fails++;
      $display("FAIL test_load timing: got to=%0d stall=%0d req=%0d fb=%0d bb=%0d required 0/2/1/0/0",
               to, sc, rc, fb, bb);
    end
    tick();
    checks++;
    if (ReadDataW !== 24'hABCDEF || ResultW !== 24'hABCDEF) begin
      fails++;
      $display("FAIL test_load data: got ReadDataW=%h ResultW=%h required abcdef", ReadDataW, ResultW);
    end
    checks++;
    if (RegWriteW !== 1'b1 || RD_W !== 5'd5 || ResultSrcW !== 1'b1 || MemErrW !== 1'b0 ||
        PCPlus4W !== 24'h000204) begin
      fails++;
      $display("FAIL test_load ctrl: got rw=%b rd=%0d rs=%b err=%b pc=%h required 1/5/1/0/000204",
               RegWriteW, RD_W, ResultSrcW, MemErrW, PCPlus4W);
    end
    $display("[%0t] test_load: ReadDataW=%h cycles=%0d", $time, ReadDataW, sc + 1);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic test_abort();
    int sc, rc, fb, bb, to;
    set_m(1'b1, 1'b0, 1'b1, 5'd6, 24'h000300, 24'h000040, 24'h0);
    drive_access(0, 24'h0, 1'b0, 24'h000040, 24'h0, sc, rc, fb, bb, to);
    checks++;
    if (to != 0 || sc != 16 || rc != 15 || fb != 0 || bb != 0) begin
      fails++;
      $display("FAIL test_abort timing: got to=%0d stall=%0d req=%0d fb=%0d bb=%0d required 0/16/15/0/0",
               to, sc, rc, fb, bb);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL test_abort req_drop: got mem_req=%b required 0", mem_req);
    end
    tick();
    checks++;
    if (MemErrW !== 1'b1 || RegWriteW !== 1'b0 || ReadDataW !== 24'h0 || RD_W !== 5'd6) begin
      fails++;
      $display("FAIL test_abort commit: got err=%b rw=%b rd=%h RD_W=%0d required 1/0/0/6",
               MemErrW, RegWriteW, ReadDataW, RD_W);
    end
    set_m(1'b1, 1'b0, 1'b0, 5'd8, 24'h000304, 24'h000055, 24'h0);
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      fails++;
      $display("FAIL test_abort next_stall: got %b required 0", StallM);
    end
    tick();
    checks++;
    if (MemErrW !== 1'b0 || RegWriteW !== 1'b1 || ResultW !== 24'h000055 || RD_W !== 5'd8) begin
      fails++;
      $display("FAIL test_abort next_op: got err=%b rw=%b res=%h RD_W=%0d required 0/1/000055/8",
               MemErrW, RegWriteW, ResultW, RD_W);
    end
    $display("[%0t] test_abort: req_cycles=%0d then ALU ResultW=%h", $time, rc, ResultW);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic test_async_reset();
    set_m(1'b1, 1'b0, 1'b1, 5'd4, 24'h000500, 24'h000060, 24'h0);
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL test_async_reset pre_req: got mem_req=%b required 1", mem_req);
    end
    #2;
    rst = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
    #1;
    checks++;
    if (mem_req !== 1'b0 || StallM !== 1'b0 || mem_addr !== 24'h0) begin
      fails++;
      $display("FAIL test_async_reset req: got req=%b stall=%b addr=%h required 0/0/0",
               mem_req, StallM, mem_addr);
    end
    checks++;
    if (RD_W !== 5'd0 || ALU_ResultW !== 24'h0 || PCPlus4W !== 24'h0 || ResultW !== 24'h0) begin
      fails++;
      $display("FAIL test_async_reset w: got RD_W=%0d alu=%h pc=%h res=%h required 0",
               RD_W, ALU_ResultW, PCPlus4W, ResultW);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    set_m(1'b1, 1'b0, 1'b0, 5'd7, 24'h000600, 24'd9, 24'h0);
    tick();
    checks++;
    if (ResultW !== 24'd9 || RegWriteW !== 1'b1 || mem_req !== 1'b0 || StallM !== 1'b0) begin
      fails++;
      $display("FAIL test_async_reset after: got res=%h rw=%b req=%b stall=%b required 000009/1/0/0",
               ResultW, RegWriteW, mem_req, StallM);
    end
    $display("[%0t] test_async_reset: ResultW=%0d", $time, ResultW);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic test_stray_and_edge_ack();
    int sc, rc, fb, bb, to;
    set_m(1'b1, 1'b0, 1'b0, 5'd2, 24'h000400, 24'h000077, 24'h0);
    mem_ack   = 1'b1;
    mem_rdata = 24'hDEAD00;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (ReadDataW !== 24'h0 || ResultW !== 24'h000077 || StallM !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL test_stray_ack: got rd=%h res=%h stall=%b req=%b required 0/000077/0/0",
               ReadDataW, ResultW, StallM, mem_req);
    end
    set_m(1'b1, 1'b0, 1'b1, 5'd9, 24'h000404, 24'h000080, 24'h0);
    drive_access(15, 24'h13579B, 1'b0, 24'h000080, 24'h0, sc, rc, fb, bb, to);
    checks++;
    if (to != 0 || sc != 16 || rc != 15 || fb != 0 || bb != 0) begin
      fails++;
      $display("FAIL test_edge_ack timing: got to=%0d stall=%0d req=%0d fb=%0d bb=%0d required 0/16/15/0/0",
               to, sc, rc, fb, bb);
    end
    tick();
    checks++;
    if (MemErrW !== 1'b0 || ReadDataW !== 24'h13579B || RegWriteW !== 1'b1 || ResultW !== 24'h13579B) begin
      fails++;
      $display("FAIL test_edge_ack commit: got err=%b rd=%h rw=%b res=%h required 0/13579b/1/13579b",
               MemErrW, ReadDataW, RegWriteW, ResultW);
    end
    $display("[%0t] test_stray_and_edge_ack: ReadDataW=%h MemErrW=%b", $time, ReadDataW, MemErrW);
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 24'h0, 24'h0, 24'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_abort();
    test_async_reset();
    test_stray_and_edge_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
